ddr2_blk_wr_arb: RTL

- Round-robin arbiter and write sequencer that shares the 72-bit write port of the 72b-in/288b-out DDR2 width-conversion FIFO among NUM_SRC block sources.
- Grants one source at a time for exactly one block of BLK_WORDS 72-bit words, pulls the words from that source's FIFO and drives the conversion FIFO's wr_en/din pair.
- Honours the one-cycle din-after-wr_en timing, throttles on full, and flushes partial 288-bit residue on abort.

---
 rtl/ddr2_blk_pkg.sv | 23 ++
 rtl/ddr2_blk_wr_arb_rr_pick.sv | 35 +++
 rtl/ddr2_blk_wr_arb.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ddr2_blk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_blk_pkg
// Description : Shared types and constants for the DDR2 block write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr2_blk_pkg;

  // Width of one source word and of the conversion FIFO write port
  localparam int DATA_W        = 72;
  // Default block length in 72-bit words (four words per 288-bit output word)
  localparam int BLK_WORDS_DEF = 64;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ddr2_blk_wr_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns a one-hot grant for
//               the first requester at or after ptr, wrapping cyclically.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_SRC = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Scan from ptr upwards, wrapping, and keep only the first requester found
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      idx = PTR_W'((int'(ptr) + off) % NUM_SRC);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ddr2_blk_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_blk_wr_arb
// Description : Round-robin block arbiter and write sequencer feeding the
//               72-bit write port of the 72b-in/288b-out DDR2 conversion FIFO.
//               One source owns the port for exactly BLK_WORDS words; words
//               are popped and written in the same cycle, data follows one
//               cycle later. Abort discards partially packed residue.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr2_blk_wr_arb
  import ddr2_blk_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int BLK_WORDS = BLK_WORDS_DEF,
  parameter int CNT_W     = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC-1:0]        src_empty,
  output logic [NUM_SRC-1:0]        src_rd_en,
  input  logic [DATA_W*NUM_SRC-1:0] src_dout,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_din,
  input  logic                      fifo_full,
  output logic                      fifo_wr_clear_residue,
  input  logic                      abort,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      blk_done,
  output logic                      busy
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t              state;
  state_t              state_nxt;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    rr_ptr_nxt;
  logic [PTR_W-1:0]    owner_idx;
  logic [CNT_W-1:0]    word_cnt;
  logic [NUM_SRC-1:0]  pick;
  logic                src_stall;
  logic                issue;
  logic                last_word;
  logic [NUM_SRC-1:0]  g_d1;
  logic                wr_d1;
  logic [DATA_W-1:0]   din_sel;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req   (src_req),
    .ptr   (rr_ptr),
    .grant (pick)
  );

  // Index of the current owner and the pointer value one past it
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) owner_idx = PTR_W'(i);
    end
    if (owner_idx == PTR_W'(NUM_SRC - 1)) rr_ptr_nxt = '0;
    else                                  rr_ptr_nxt = owner_idx + 1'b1;
  end

  // Issue qualification: full, owner-empty and abort all block a word
  always_comb begin
    src_stall = |(src_empty & grant);
    issue     = (state == XFER) && !fifo_full && !src_stall && !abort;
    last_word = (word_cnt == CNT_W'(BLK_WORDS - 1));
  end

  // Next-state and strobe decoding
  always_comb begin
    state_nxt             = state;
    fifo_wr_en            = issue;
    src_rd_en             = issue ? grant : '0;
    blk_done              = 1'b0;
    fifo_wr_clear_residue = 1'b0;
    busy                  = (state != IDLE);
    case (state)
      IDLE: begin
        if (|src_req) state_nxt = XFER;
      end
      XFER: begin
        if (abort)                  state_nxt = FLUSH;
        else if (issue && last_word) state_nxt = DONE;
      end
      DONE: begin
        // An abort landing on the completion cycle still drops the block
        blk_done  = !abort;
        state_nxt = abort ? FLUSH : IDLE;
      end
      FLUSH: begin
        fifo_wr_clear_residue = 1'b1;
        state_nxt             = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: state, owner, round-robin pointer, word counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          word_cnt <= '0;
          if (|src_req) grant <= pick;
        end
        XFER: begin
          if (issue) word_cnt <= word_cnt + 1'b1;
        end
        DONE, FLUSH: begin
          // Ownership ends only when the block is truly retired to IDLE
          if (state_nxt == IDLE) begin
            grant  <= '0;
            rr_ptr <= rr_ptr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Data path select delayed to line up with the source read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      g_d1  <= '0;
      wr_d1 <= 1'b0;
    end else begin
      g_d1  <= grant;
      wr_d1 <= fifo_wr_en;
    end
  end

  // Steer the owner's word onto fifo_din, zero when no write is in flight
  always_comb begin
    din_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (g_d1[i]) din_sel = din_sel | src_dout[i*DATA_W +: DATA_W];
    end
    fifo_din = wr_d1 ? din_sel : '0;
  end

endmodule
`default_nettype wire
